bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
- Sits directly upstream of the 4-digit display stage.
- Converts an unsigned binary count into four BCD nibbles for the display's 4x4-bit digit input.
- Holds the result stable between conversions, so the display can sample it at any time.

---
 rtl/bin2bcd_seq_if.sv | 22 ++
 rtl/bin2bcd_seq.sv | 131 +++++++++++++
 tb/tb_bin2bcd_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary source and bin2bcd_seq.
// bcd_o index 0 is the thousands digit, index 3 the units digit.
interface bin2bcd_seq_if #(
   parameter int unsigned BIN_W = 14
);
   logic [BIN_W-1:0] bin_i;
   logic             start_i;
   logic             busy_o;
   logic             done_o;
   logic             ovf_o;
   logic [3:0][3:0]  bcd_o;

   modport master (
      output bin_i, start_i,
      input  busy_o, done_o, ovf_o, bcd_o
   );

   modport slave (
      input  bin_i, start_i,
      output busy_o, done_o, ovf_o, bcd_o
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SATURATE_EN to clamp overflowing inputs to 9999 instead of showing EEEE.
module bin2bcd_seq #(
   parameter int unsigned BIN_W = 14
) (
   input  logic          clk_i,
   input  logic          porb_i,
   input  logic          sync_reset_i,
   bin2bcd_seq_if.slave  bus
);

   localparam int unsigned MAX_VAL = 9999;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e           state_q, state_d;
   logic [BIN_W-1:0] bin_sh_q, bin_sh_d;
   logic [15:0]      scr_q, scr_d, scr_adj;
   logic [4:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             ovf_out_q, ovf_out_d;
   logic             done_q, done_d;
   logic [3:0][3:0]  bcd_q, bcd_d;
   logic             over_max;
   logic [BIN_W-1:0] load_val;

   // Narrow inputs cannot exceed 9999, so the comparator is dropped entirely.
   if (BIN_W > 13) begin : g_ovf
      assign over_max = (32'(bus.bin_i) > MAX_VAL);
   end else begin : g_no_ovf
      assign over_max = 1'b0;
   end

`ifdef BIN2BCD_SATURATE_EN
   assign load_val = over_max ? BIN_W'(MAX_VAL) : bus.bin_i;
`else
   assign load_val = bus.bin_i;
`endif

   // Per-nibble correction, no carry between digits.
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i < 4; i++) begin
         scr_adj[4*i +: 4] = scr_q[4*i +: 4] + ((scr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
      end
   end

   always_comb begin
      state_d   = state_q;
      bin_sh_d  = bin_sh_q;
      scr_d     = scr_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      ovf_out_d = ovf_out_q;
      done_d    = 1'b0;
      bcd_d     = bcd_q;

      unique case (state_q)
         StIdle: begin
            if (bus.start_i) begin
               bin_sh_d = load_val;
               scr_d    = '0;
               cnt_d    = 5'(BIN_W);
               ovf_d    = over_max;
               state_d  = StShift;
            end
         end
         StShift: begin
            {scr_d, bin_sh_d} = {scr_adj, bin_sh_q} << 1;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) begin
               state_d = StDone;
            end
         end
         StDone: begin
            // Scratch holds thousands in its top nibble; bcd index 0 is thousands.
            for (int i = 0; i < 4; i++) begin
               bcd_d[i] = scr_q[12-4*i +: 4];
            end
`ifndef BIN2BCD_SATURATE_EN
            if (ovf_q) begin
               bcd_d = {4{4'hE}};
            end
`endif
            ovf_out_d = ovf_q;
            done_d    = 1'b1;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (sync_reset_i) begin
         state_d   = StIdle;
         bin_sh_d  = '0;
         scr_d     = '0;
         cnt_d     = '0;
         ovf_d     = 1'b0;
         ovf_out_d = 1'b0;
         done_d    = 1'b0;
         bcd_d     = '0;
      end
   end

   always_ff @(posedge clk_i or negedge porb_i) begin
      if (!porb_i) begin
         state_q   <= StIdle;
         bin_sh_q  <= '0;
         scr_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         ovf_out_q <= 1'b0;
         done_q    <= 1'b0;
         bcd_q     <= '0;
      end else begin
         state_q   <= state_d;
         bin_sh_q  <= bin_sh_d;
         scr_q     <= scr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         ovf_out_q <= ovf_out_d;
         done_q    <= done_d;
         bcd_q     <= bcd_d;
      end
   end

   assign bus.busy_o = (state_q != StIdle);
   assign bus.done_o = done_q;
   assign bus.ovf_o  = ovf_out_q;
   assign bus.bcd_o  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Randomized self-checking bench for bin2bcd_seq against an arithmetic reference model.
module tb_bin2bcd_seq;

   localparam int unsigned W = 14;

   logic clk_i = 1'b0;
   logic porb_i = 1'b0;
   logic sync_reset_i = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   bin2bcd_seq_if #(.BIN_W(W)) bus ();

   bin2bcd_seq #(.BIN_W(W)) dut (
      .clk_i        (clk_i),
      .porb_i       (porb_i),
      .sync_reset_i (sync_reset_i),
      .bus          (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Decimal digits by division; index 0 = thousands.
   function automatic logic [15:0] ref_bcd(input int unsigned v);
      logic [3:0][3:0] e;
      int unsigned d;
      d = v;
      if (v > 9999) begin
`ifdef BIN2BCD_SATURATE_EN
         d = 9999;
`else
         return 16'hEEEE;
`endif
      end
      e[0] = 4'(d / 1000);
      e[1] = 4'((d / 100) % 10);
      e[2] = 4'((d / 10) % 10);
      e[3] = 4'(d % 10);
      return e;
   endfunction

   task automatic run_conv(input int unsigned v, input string tag);
      int  cyc;
      int  busy_cyc;
      bit  seen;
      @(negedge clk_i);
      bus.bin_i   = W'(v);
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      bus.bin_i   = W'($urandom);
      cyc = 0;
      busy_cyc = 0;
      seen = 1'b0;
      while (!seen && cyc < 40) begin
         if (bus.busy_o) busy_cyc++;
         @(posedge clk_i);
         #1;
         cyc++;
         if (bus.done_o) seen = 1'b1;
      end
      chk({tag, " latency"}, 32'(cyc), 32'(W + 1));
      chk({tag, " busy_cycles"}, 32'(busy_cyc), 32'(W + 1));
      chk({tag, " busy_at_done"}, 32'(bus.busy_o), 32'd0);
      chk({tag, " bcd"}, 32'(bus.bcd_o), 32'(ref_bcd(v)));
      chk({tag, " ovf"}, 32'(bus.ovf_o), 32'(v > 9999));
      @(posedge clk_i);
      #1;
      chk({tag, " done_one_cycle"}, 32'(bus.done_o), 32'd0);
      chk({tag, " bcd_hold"}, 32'(bus.bcd_o), 32'(ref_bcd(v)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int unsigned vals[$];
      int unsigned bounds[$];
      int          done_seen;

      bus.bin_i   = '0;
      bus.start_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset bcd", 32'(bus.bcd_o), 32'd0);
      chk("reset busy", 32'(bus.busy_o), 32'd0);
      chk("reset done", 32'(bus.done_o), 32'd0);
      chk("reset ovf", 32'(bus.ovf_o), 32'd0);
      @(negedge clk_i);
      porb_i = 1'b1;

      // Idle for 20 clocks with no start.
      done_seen = 0;
      repeat (20) begin
         @(posedge clk_i);
         #1;
         if (bus.done_o) done_seen++;
      end
      chk("idle done_count", 32'(done_seen), 32'd0);
      chk("idle bcd", 32'(bus.bcd_o), 32'd0);
      chk("idle busy", 32'(bus.busy_o), 32'd0);

      run_conv(2025, "v2025");

      bounds = '{0, 9, 10, 999, 1000, 9999, 10000, 16383, 42};
      foreach (bounds[i]) run_conv(bounds[i], $sformatf("v%0d", bounds[i]));

      repeat (8) begin
         int unsigned r;
         r = $urandom_range(0, 16383);
         run_conv(r, $sformatf("rand%0d", r));
      end

      // Continuous start: accepted every W+2 clocks, each result tied to its accept edge.
      vals.delete();
      for (int k = 0; k < 4 * (W + 2); k++) begin
         int unsigned r;
         @(negedge clk_i);
         r = $urandom_range(0, 16383);
         vals.push_back(r);
         bus.bin_i   = W'(r);
         bus.start_i = 1'b1;
         @(posedge clk_i);
         #1;
         if ((k % (W + 2)) == W + 1) begin
            chk($sformatf("b2b done k%0d", k), 32'(bus.done_o), 32'd1);
            chk($sformatf("b2b bcd k%0d", k), 32'(bus.bcd_o), 32'(ref_bcd(vals[k - (W + 1)])));
            chk($sformatf("b2b ovf k%0d", k), 32'(bus.ovf_o), 32'(vals[k - (W + 1)] > 9999));
         end else begin
            chk($sformatf("b2b no_done k%0d", k), 32'(bus.done_o), 32'd0);
         end
      end
      @(negedge clk_i);
      bus.start_i = 1'b0;

      // Async reset in the 7th shift cycle.
      run_conv(5678, "pre_async");
      @(negedge clk_i);
      bus.bin_i   = W'(1234);
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      repeat (6) @(posedge clk_i);
      #2;
      porb_i = 1'b0;
      #1;
      chk("async bcd", 32'(bus.bcd_o), 32'd0);
      chk("async busy", 32'(bus.busy_o), 32'd0);
      chk("async ovf", 32'(bus.ovf_o), 32'd0);
      @(negedge clk_i);
      porb_i = 1'b1;
      done_seen = 0;
      repeat (20) begin
         @(posedge clk_i);
         #1;
         if (bus.done_o) done_seen++;
      end
      chk("async no_done", 32'(done_seen), 32'd0);
      run_conv(4321, "post_async");

      // Same abort via synchronous reset.
      @(negedge clk_i);
      bus.bin_i   = W'(1234);
      bus.start_i = 1'b1;
      @(posedge clk_i);
      #1;
      bus.start_i = 1'b0;
      repeat (6) @(posedge clk_i);
      @(negedge clk_i);
      chk("sync pre bcd_held", 32'(bus.bcd_o), 32'(ref_bcd(4321)));
      sync_reset_i = 1'b1;
      @(posedge clk_i);
      #1;
      chk("sync bcd", 32'(bus.bcd_o), 32'd0);
      chk("sync busy", 32'(bus.busy_o), 32'd0);
      @(negedge clk_i);
      sync_reset_i = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(posedge clk_i);
         #1;
         if (bus.done_o) done_seen++;
      end
      chk("sync no_done", 32'(done_seen), 32'd0);
      run_conv(4321, "post_sync");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
